// File: rtl/rega_write_arbiter_if.sv
// Requester-side bus for the register A write arbiter: level requests with
// flattened write data in, one-hot grant/ack and the register A load port out.
interface rega_write_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 16
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] wdata;
    logic [N_REQ-1:0]        grant;
    logic [N_REQ-1:0]        ack;
    logic                    loadA;
    logic [DATA_W-1:0]       dataAin;
    logic                    busy;

    modport master (
        output req, wdata,
        input  grant, ack, loadA, dataAin, busy
    );

    modport slave (
        input  req, wdata,
        output grant, ack, loadA, dataAin, busy
    );
endinterface

// File: rtl/rega_write_arbiter.sv
// Round-robin arbiter that owns register A's load port: picks one requester,
// strobes loadA/dataAin for one cycle, then returns a one-cycle ack.
module rega_write_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 16,
    parameter int PTR_W  = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    rega_write_arbiter_if.slave bus
);
    // state | meaning
    // IDLE  | waiting; a nonzero req picks a winner from ptr onward
    // LOAD  | loadA high for one cycle, data frozen at grant
    // ACK   | ack pulse to the winner, pointer moved past it
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic              load_q, load_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W-1:0]  owner_q, owner_d;

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [N_REQ-1:0]   win_onehot;
    logic               win_found;
    logic [PTR_W-1:0]   win_off;
    logic [PTR_W:0]     win_sum;
    logic [PTR_W-1:0]   win_idx;
    logic [DATA_W-1:0]  win_data;

    // Rotating a doubled copy puts requester ptr at bit 0, so the lowest set
    // bit is the next requester in round-robin order.
    assign req_dbl = {bus.req, bus.req} >> ptr_q;
    assign req_rot = req_dbl[N_REQ-1:0];

    always_comb begin
        win_found = 1'b0;
        win_off   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                win_found = 1'b1;
                win_off   = PTR_W'(k);
            end
        end
        win_sum = {1'b0, ptr_q} + {1'b0, win_off};
        win_idx = (win_sum >= (PTR_W + 1)'(N_REQ)) ?
                  PTR_W'(win_sum - (PTR_W + 1)'(N_REQ)) : win_sum[PTR_W-1:0];
        win_data   = '0;
        win_onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == PTR_W'(i)) begin
                win_data      = bus.wdata[i*DATA_W +: DATA_W];
                win_onehot[i] = win_found;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ack_q   <= '0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            load_q  <= load_d;
            busy_q  <= busy_d;
            data_q  <= data_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_found) state_d = LOAD;
            LOAD:    state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_d = grant_q;
        ack_d   = '0;
        load_d  = 1'b0;
        busy_d  = busy_q;
        data_d  = data_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        case (state_q)
            IDLE: begin
                grant_d = win_onehot;
                load_d  = win_found;
                busy_d  = win_found;
                data_d  = win_found ? win_data : '0;
                owner_d = win_idx;
            end
            LOAD: begin
                ack_d = grant_q;
                ptr_d = (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
            end
            ACK: begin
                grant_d = '0;
                busy_d  = 1'b0;
            end
            default: begin
                grant_d = '0;
                busy_d  = 1'b0;
                data_d  = '0;
            end
        endcase
    end

    assign bus.grant   = grant_q;
    assign bus.ack     = ack_q;
    assign bus.loadA   = load_q;
    assign bus.busy    = busy_q;
    assign bus.dataAin = data_q;
endmodule

// File: tb/tb_rega_write_arbiter.sv
// Bench for rega_write_arbiter: directed scenarios plus random requests, all
// checked against a transaction-level round-robin model.
module tb_rega_write_arbiter;
    localparam int N  = 4;
    localparam int DW = 16;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    rega_write_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();

    rega_write_arbiter #(.N_REQ(N), .DATA_W(DW), .PTR_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Register A as seen by the datapath
    logic [DW-1:0] reg_a;
    always @(posedge clk) if (bus.loadA) reg_a <= bus.dataAin;

    // Reference model: each accepted request expands into the three cycles of
    // outputs it produces; new requests are only looked at once those are spent.
    typedef struct {
        logic [N-1:0]  grant;
        logic [N-1:0]  ack;
        logic          load;
        logic [DW-1:0] data;
        logic          busy;
        logic          chk_d;
    } exp_t;

    exp_t q[$];
    int   m_ptr;

    always begin
        exp_t e;
        logic [N-1:0]    r;
        logic [N*DW-1:0] wd;
        int g;
        @(posedge clk);
        r  = bus.req;
        wd = bus.wdata;
        if (!rst_n) begin
            q.delete();
            m_ptr = 0;
            e = '{grant: '0, ack: '0, load: 1'b0, data: '0, busy: 1'b0, chk_d: 1'b1};
        end else if (q.size() == 0) begin
            g = -1;
            for (int k = 0; k < N; k++)
                if (g < 0 && r[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            if (g < 0) begin
                e = '{grant: '0, ack: '0, load: 1'b0, data: '0, busy: 1'b0, chk_d: 1'b1};
            end else begin
                exp_t t;
                t.grant = N'(1) << g;
                t.data  = wd[g*DW +: DW];
                t.ack = '0;    t.load = 1'b1; t.busy = 1'b1; t.chk_d = 1'b1; q.push_back(t);
                t.ack = t.grant; t.load = 1'b0; q.push_back(t);
                t.grant = '0; t.ack = '0; t.busy = 1'b0; t.chk_d = 1'b0; q.push_back(t);
                m_ptr = (g + 1) % N;
                e = q.pop_front();
            end
        end else begin
            e = q.pop_front();
        end
        #1;
        chk("m_grant", 32'(bus.grant), 32'(e.grant));
        chk("m_ack",   32'(bus.ack),   32'(e.ack));
        chk("m_load",  32'(bus.loadA), 32'(e.load));
        chk("m_busy",  32'(bus.busy),  32'(e.busy));
        if (e.chk_d) chk("m_data", 32'(bus.dataAin), 32'(e.data));
    end

    task automatic set_wd(input int i, input logic [DW-1:0] v);
        bus.wdata[i*DW +: DW] = v;
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    initial begin
        int order[$];
        int ack_t[$];
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.req   = '0;
        bus.wdata = '0;

        // 1: reset then idle
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("idle_outs", {bus.grant, bus.ack, 3'(bus.loadA), 1'(bus.busy), bus.dataAin}, 32'h0);
        end

        // 2: single write from requester 2
        set_wd(2, 16'h00FE);
        bus.req = 4'b0100;
        @(negedge clk);
        chk("t2_grant", 32'(bus.grant), 32'h4);
        chk("t2_load",  32'(bus.loadA), 32'h1);
        chk("t2_data",  32'(bus.dataAin), 32'h00FE);
        @(negedge clk);
        chk("t2_ack",   32'(bus.ack), 32'h4);
        chk("t2_load0", 32'(bus.loadA), 32'h0);
        bus.req = 4'b0000;
        @(negedge clk);
        chk("t2_rega",  32'(reg_a), 32'h00FE);
        chk("t2_busy0", 32'(bus.busy), 32'h0);

        // 4: ptr is now 3; requesters 3 and 0 both ask, 3 goes first
        set_wd(3, 16'hA003);
        set_wd(0, 16'hB000);
        bus.req = 4'b1001;
        @(negedge clk);
        chk("t4_grant3", 32'(bus.grant), 32'h8);
        chk("t4_data3",  32'(bus.dataAin), 32'hA003);
        @(negedge clk);
        chk("t4_ack3",   32'(bus.ack), 32'h8);
        bus.req = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        chk("t4_grant0", 32'(bus.grant), 32'h1);
        chk("t4_data0",  32'(bus.dataAin), 32'hB000);
        @(negedge clk);
        chk("t4_ack0",   32'(bus.ack), 32'h1);
        bus.req = 4'b0000;
        @(negedge clk);

        // 5: ptr must be 1, so requester 1 wins over 0 and 3; late data change ignored
        set_wd(1, 16'h0FE6);
        bus.req = 4'b1011;
        @(negedge clk);
        chk("t5_grant1", 32'(bus.grant), 32'h2);
        set_wd(1, 16'h1234);
        @(negedge clk);
        chk("t5_data_hold", 32'(bus.dataAin), 32'h0FE6);
        chk("t5_ack1",      32'(bus.ack), 32'h2);
        bus.req = 4'b0000;
        @(negedge clk);
        chk("t5_rega", 32'(reg_a), 32'h0FE6);

        // 3: fairness with all requesters active from ptr = 0
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.req = 4'b1111;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (bus.loadA) order.push_back(onehot_idx(bus.grant));
            if (|bus.ack) ack_t.push_back(c);
        end
        chk("t3_count", 32'(order.size() >= 5), 32'h1);
        for (int i = 0; i < 5 && i < order.size(); i++)
            chk("t3_order", 32'(order[i]), 32'(i % N));
        for (int i = 1; i < ack_t.size(); i++)
            chk("t3_ack_gap", 32'(ack_t[i] - ack_t[i-1]), 32'd3);
        bus.req = 4'b0000;
        repeat (3) @(negedge clk);

        // random traffic, checked by the model
        for (int c = 0; c < 400; c++) begin
            bus.req   = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            bus.wdata = {$urandom, $urandom};
            @(negedge clk);
        end
        bus.req = 4'b0000;
        repeat (3) @(negedge clk);

        // 6: move ptr to 1, then reset in the middle of a LOAD
        bus.req = 4'b0001;
        @(negedge clk);
        bus.req = 4'b0000;
        repeat (2) @(negedge clk);
        set_wd(2, 16'h5555);
        bus.req = 4'b0100;
        @(posedge clk);
        #2;
        chk("t6_in_load", 32'(bus.loadA), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("t6_async", {bus.grant, bus.ack, 3'(bus.loadA), 1'(bus.busy), bus.dataAin}, 32'h0);
        bus.req = 4'b0000;
        repeat (2) begin
            @(negedge clk);
            chk("t6_no_ack", 32'(bus.ack), 32'h0);
        end
        set_wd(0, 16'hC0DE);
        set_wd(3, 16'hD00D);
        bus.req = 4'b1001;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_ptr0_grant", 32'(bus.grant), 32'h1);
        chk("t6_ptr0_data",  32'(bus.dataAin), 32'hC0DE);
        bus.req = 4'b0000;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
